// File: rtl/pipe_share_arb_pkg.sv
// Shared types and helpers for pipe_share_arb: tag struct, one-hot decode
// and the circular round-robin pick.
package pipe_share_arb_pkg;

    localparam int NREQ_MIN = 2;
    localparam int NREQ_MAX = 16;
    localparam int LAT_MIN  = 1;
    localparam int LAT_MAX  = 64;
    localparam int ID_W_MAX = 4;

    typedef struct packed {
        logic                valid;
        logic [ID_W_MAX-1:0] id;
    } tag_t;

    typedef struct packed {
        logic                found;
        logic [ID_W_MAX-1:0] idx;
    } pick_t;

    function automatic logic [NREQ_MAX-1:0] onehot(input logic [ID_W_MAX-1:0] id);
        logic [NREQ_MAX-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    // Lowest index j >= ptr (wrapping at n) whose request bit is set.
    function automatic pick_t rr_pick(input logic [NREQ_MAX-1:0] req,
                                      input logic [ID_W_MAX-1:0] ptr,
                                      input int                  n);
        pick_t p;
        int    j;
        p = '0;
        for (int k = 0; k < NREQ_MAX; k++) begin
            j = (int'(ptr) + k) % n;
            if ((k < n) && !p.found && req[j[ID_W_MAX-1:0]]) begin
                p.found = 1'b1;
                p.idx   = j[ID_W_MAX-1:0];
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/pipe_share_arb_if.sv
// Bundle of requester, shared-pipeline and response signals for pipe_share_arb.
interface pipe_share_arb_if #(
    parameter int NREQ = 4,
    parameter int DW   = 32,
    parameter int RW   = 32
);
    // A request beat transfers in any cycle where req_valid[i] & req_ready[i];
    // the requester holds valid/data stable until then. rsp_valid has no ready.
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_last;
    logic [NREQ-1:0]    req_ready;
    logic               hold;
    logic               pipe_in_valid;
    logic [DW-1:0]      pipe_in_data;
    logic [RW-1:0]      pipe_out_data;
    logic [NREQ-1:0]    rsp_valid;
    logic [RW-1:0]      rsp_data;
    logic               idle;

    modport master (
        output req_valid, req_data, req_last, hold, pipe_out_data,
        input  req_ready, pipe_in_valid, pipe_in_data, rsp_valid, rsp_data, idle
    );

    modport slave (
        input  req_valid, req_data, req_last, hold, pipe_out_data,
        output req_ready, pipe_in_valid, pipe_in_data, rsp_valid, rsp_data, idle
    );
endinterface

// File: rtl/pipe_share_arb_tag_delay.sv
// pipe_tag_delay: LATENCY-stage shift register of tags with synchronous clear,
// matching the shared pipeline's depth so ids line up with results.
module pipe_tag_delay
    import pipe_share_arb_pkg::*;
#(
    parameter int LATENCY = 2
) (
    input  logic clk,
    input  logic clr_i,
    input  tag_t d_i,
    output tag_t q_o
);

    tag_t stage_q [LATENCY];

    always_ff @(posedge clk) begin
        if (clr_i) begin
            for (int i = 0; i < LATENCY; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < LATENCY; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign q_o = stage_q[LATENCY-1];

endmodule

// File: rtl/pipe_share_arb.sv
// Round-robin sharing of one fixed-latency pipeline among NREQ requesters.
// Define PIPE_ARB_BURST_EN to lock the grant across req_last-terminated bursts.
module pipe_share_arb
    import pipe_share_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int DW      = 32,
    parameter int RW      = 32,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst,
    pipe_share_arb_if.slave  bus
);

    localparam int ID_W  = $clog2(NREQ);
    localparam int CNT_W = $clog2(LATENCY + 1);

    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [ID_W-1:0]  ptr_nxt;
    pick_t            pick;
    logic             cand_found;
    logic [ID_W-1:0]  cand_id;
    logic             grant;
    tag_t             tag_in, tag_out;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb pick = rr_pick(NREQ_MAX'(bus.req_valid), ID_W_MAX'(ptr_q), NREQ);

`ifdef PIPE_ARB_BURST_EN
    logic            lock_q, lock_d;
    logic [ID_W-1:0] lock_id_q, lock_id_d;

    // While locked, only the burst owner may issue, even if it is momentarily idle.
    always_comb begin
        cand_found = lock_q ? bus.req_valid[lock_id_q] : pick.found;
        cand_id    = lock_q ? lock_id_q : ID_W'(pick.idx);
    end
`else
    logic unused_last;
    assign unused_last = ^bus.req_last;
    assign cand_found  = pick.found;
    assign cand_id     = ID_W'(pick.idx);
`endif

    assign grant   = cand_found & ~bus.hold & ~rst;
    assign ptr_nxt = (cand_id == ID_W'(NREQ - 1)) ? '0 : cand_id + ID_W'(1);

    assign bus.req_ready     = grant ? NREQ'(onehot(ID_W_MAX'(cand_id))) : '0;
    assign bus.pipe_in_valid = grant;

    always_comb begin
        bus.pipe_in_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (cand_id == ID_W'(i)) bus.pipe_in_data = bus.req_data[i*DW +: DW];
        end
    end

    always_comb begin
        ptr_d = ptr_q;
`ifdef PIPE_ARB_BURST_EN
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        if (grant) begin
            if (bus.req_last[cand_id]) begin
                ptr_d  = ptr_nxt;
                lock_d = 1'b0;
            end else begin
                lock_d    = 1'b1;
                lock_id_d = cand_id;
            end
        end
`else
        if (grant) ptr_d = ptr_nxt;
`endif
    end

    always_comb begin
        tag_in.valid = grant;
        tag_in.id    = ID_W_MAX'(cand_id);
    end

    pipe_tag_delay #(.LATENCY(LATENCY)) u_tag_delay (
        .clk   (clk),
        .clr_i (rst),
        .d_i   (tag_in),
        .q_o   (tag_out)
    );

    assign bus.rsp_valid = tag_out.valid ? NREQ'(onehot(tag_out.id)) : '0;
    assign bus.rsp_data  = bus.pipe_out_data;

    // Issue and retire in the same cycle cancel out, so the count tops out at LATENCY.
    always_comb begin
        cnt_d = cnt_q;
        case ({grant, tag_out.valid})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    assign bus.idle = (cnt_q == '0) & ~grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

`ifdef PIPE_ARB_BURST_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q    <= 1'b0;
            lock_id_q <= '0;
        end else begin
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_share_arb.sv
// Directed bench for pipe_share_arb: three instances at LATENCY 2, 4 and 1.
module tb_pipe_share_arb;

    logic clk = 1'b0;
    logic rst2, rst4, rst1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    pipe_share_arb_if #(.NREQ(4), .DW(32), .RW(32)) bus2 ();
    pipe_share_arb_if #(.NREQ(4), .DW(32), .RW(32)) bus4 ();
    pipe_share_arb_if #(.NREQ(4), .DW(32), .RW(32)) bus1 ();

    pipe_share_arb #(.NREQ(4), .DW(32), .RW(32), .LATENCY(2)) u_dut2 (
        .clk (clk), .rst (rst2), .bus (bus2.slave));
    pipe_share_arb #(.NREQ(4), .DW(32), .RW(32), .LATENCY(4)) u_dut4 (
        .clk (clk), .rst (rst4), .bus (bus4.slave));
    pipe_share_arb #(.NREQ(4), .DW(32), .RW(32), .LATENCY(1)) u_dut1 (
        .clk (clk), .rst (rst1), .bus (bus1.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    int exp_rdy_c [8] = '{2, 0, 0, 0, 8, 2, 0, 0};
    int exp_rsp_c [8] = '{0, 0, 2, 0, 0, 0, 8, 2};
    int hold_c    [8] = '{0, 1, 1, 1, 0, 0, 0, 0};
`ifdef PIPE_ARB_BURST_EN
    int exp_rdy_e [6] = '{2, 2, 2, 1, 1, 1};
`else
    int exp_rdy_e [6] = '{2, 1, 2, 1, 2, 1};
`endif

    initial begin
        int beat;
        rst2 = 1'b1; rst4 = 1'b1; rst1 = 1'b1;
        bus2.req_valid = 4'b1111; bus2.req_data = '0; bus2.req_last = 4'b1111;
        bus2.hold = 1'b0; bus2.pipe_out_data = 32'hDEAD_BEEF;
        bus4.req_valid = 4'b0100; bus4.req_data = '0; bus4.req_last = 4'b1111;
        bus4.hold = 1'b0; bus4.pipe_out_data = '0;
        bus1.req_valid = '0; bus1.req_data = '0; bus1.req_last = 4'b1111;
        bus1.hold = 1'b0; bus1.pipe_out_data = '0;
        adv();

        // Reset state, with requests present
        settle();
        chk("rst ready", 32'(bus2.req_ready), 0);
        chk("rst piv", 32'(bus2.pipe_in_valid), 0);
        chk("rst rsp_valid", 32'(bus2.rsp_valid), 0);
        chk("rst idle", 32'(bus2.idle), 1);
        chk("rst rsp_data", bus2.rsp_data, 32'hDEAD_BEEF);
        chk("rst4 ready", 32'(bus4.req_ready), 0);
        adv();
        bus2.req_valid = '0;
        rst2 = 1'b0;

        // Single requester 2, three beats
        for (int c = 0; c < 6; c++) begin
            bus2.req_valid = (c < 3) ? 4'b0100 : 4'b0000;
            bus2.req_data[2*32 +: 32] = 32'hA000_0000 + c;
            bus2.pipe_out_data = 32'hB000_0000 + c;
            settle();
            if (c < 3) begin
                chk("A ready", 32'(bus2.req_ready), 4);
                chk("A piv", 32'(bus2.pipe_in_valid), 1);
                chk("A pid", bus2.pipe_in_data, 32'hA000_0000 + c);
            end else begin
                chk("A ready idle", 32'(bus2.req_ready), 0);
            end
            chk("A rsp_valid", 32'(bus2.rsp_valid), (c >= 2 && c < 5) ? 4 : 0);
            if (c >= 2 && c < 5) chk("A rsp_data", bus2.rsp_data, 32'hB000_0000 + c);
            if (c == 3) chk("A idle busy", 32'(bus2.idle), 0);
            if (c == 5) chk("A idle drained", 32'(bus2.idle), 1);
            adv();
        end

        // Reset, then all four requesters valid continuously
        rst2 = 1'b1;
        adv();
        rst2 = 1'b0;
        for (int i = 0; i < 4; i++) bus2.req_data[i*32 +: 32] = 32'hD000_0000 + i;
        for (int c = 0; c < 11; c++) begin
            bus2.req_valid = (c < 8) ? 4'b1111 : 4'b0000;
            bus2.pipe_out_data = 32'hE000_0000 + c;
            settle();
            chk("B ready", 32'(bus2.req_ready), (c < 8) ? (1 << (c % 4)) : 0);
            if (c < 8) chk("B pid", bus2.pipe_in_data, 32'hD000_0000 + (c % 4));
            chk("B rsp_valid", 32'(bus2.rsp_valid),
                (c >= 2 && c < 10) ? (1 << ((c - 2) % 4)) : 0);
            if (c >= 2 && c < 10) chk("B rsp_data", bus2.rsp_data, 32'hE000_0000 + c);
            if (c == 10) chk("B idle", 32'(bus2.idle), 1);
            adv();
        end

        // hold for three cycles with requesters 1 and 3 valid
        for (int c = 0; c < 8; c++) begin
            bus2.req_valid = (c < 6) ? 4'b1010 : 4'b0000;
            bus2.hold = hold_c[c][0];
            settle();
            chk("C ready", 32'(bus2.req_ready), exp_rdy_c[c]);
            chk("C piv", 32'(bus2.pipe_in_valid), (exp_rdy_c[c] != 0) ? 1 : 0);
            chk("C rsp_valid", 32'(bus2.rsp_valid), exp_rsp_c[c]);
            if (c == 1) chk("C idle inflight", 32'(bus2.idle), 0);
            if (c == 3) chk("C idle drained", 32'(bus2.idle), 1);
            adv();
        end
        bus2.hold = 1'b0;

        // Single beat from requester 0 moves ptr to 1
        bus2.req_valid = 4'b0001;
        bus2.req_last  = 4'b1111;
        bus2.req_data[0*32 +: 32] = 32'hC000_0000;
        settle();
        chk("E pre ready", 32'(bus2.req_ready), 1);
        adv();

        // Requester 1 three-beat burst while requester 0 stays valid
        beat = 0;
        for (int c = 0; c < 6; c++) begin
            bus2.req_valid = {2'b00, (beat < 3), 1'b1};
            bus2.req_last  = {2'b11, (beat == 2), 1'b1};
            bus2.req_data[1*32 +: 32] = 32'hF000_0000 + beat;
            settle();
            chk("E ready", 32'(bus2.req_ready), exp_rdy_e[c]);
            chk("E pid", bus2.pipe_in_data,
                (exp_rdy_e[c] == 2) ? (32'hF000_0000 + beat) : 32'hC000_0000);
            adv();
            if (exp_rdy_e[c] == 2) beat++;
        end
        bus2.req_valid = '0;
        for (int c = 0; c < 3; c++) adv();
        settle();
        chk("E idle drained", 32'(bus2.idle), 1);
        adv();

        // LATENCY=4: reset one cycle after an issue discards the op
        for (int c = 1; c < 9; c++) begin
            rst4 = (c == 2);
            bus4.req_valid = (c == 1) ? 4'b0100 : (c == 4) ? 4'b1001 : 4'b0000;
            settle();
            if (c == 1) chk("D ready issue", 32'(bus4.req_ready), 4);
            if (c == 2) chk("D ready in rst", 32'(bus4.req_ready), 0);
            if (c == 3) chk("D idle after rst", 32'(bus4.idle), 1);
            if (c == 4) chk("D ptr zero grant", 32'(bus4.req_ready), 1);
            chk("D rsp_valid", 32'(bus4.rsp_valid), (c == 8) ? 1 : 0);
            adv();
        end

        // LATENCY=1: back-to-back issue and retire
        for (int c = 1; c < 6; c++) begin
            rst1 = 1'b0;
            bus1.req_valid = (c < 4) ? 4'b0001 : 4'b0000;
            settle();
            chk("G ready", 32'(bus1.req_ready), (c < 4) ? 1 : 0);
            chk("G rsp_valid", 32'(bus1.rsp_valid), (c >= 2 && c < 5) ? 1 : 0);
            chk("G idle", 32'(bus1.idle), (c == 5) ? 1 : 0);
            adv();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
